// File: rtl/shift_reg_ctrl.sv
// Command-driven controller for an external shift register: parallel load or N-cycle shift.
// Optional REG_ENB rising-edge activity counter on tr_cnt when TRANS_CNT_EN is defined.
module shift_reg_ctrl #(
   parameter int SHIFT_W = 4,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [CNT_W-1:0]   cmd_n,
   input  logic [SHIFT_W-1:0] cmd_data,
   input  logic               s_in,
   output logic [1:0]         reg_mode,
   output logic               reg_enb,
   output logic [SHIFT_W-1:0] reg_d,
   output logic               reg_s_in,
   output logic               busy,
   output logic               done,
   output logic [15:0]        tr_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic [1:0]         reg_mode_q, reg_mode_d;
   logic               reg_enb_q, reg_enb_d;
   logic [SHIFT_W-1:0] reg_d_q, reg_d_d;
   logic               reg_s_in_q, reg_s_in_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      reg_d_d    = reg_d_q;
      reg_s_in_d = reg_s_in_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d  = cmd_op;
               cnt_d = cmd_n;
               if (cmd_op == 2'b01) begin
                  state_d = LOAD;
                  reg_d_d = cmd_data;
               end else if (cmd_op[1] && (cmd_n != '0)) begin
                  state_d    = SHIFT;
                  reg_s_in_d = s_in;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LOAD:  state_d = DONE;
         SHIFT: begin
            if (cnt_q == CNT_W'(1)) state_d = DONE;
            else                    cnt_d   = cnt_q - CNT_W'(1);
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      reg_enb_d   = (state_d == LOAD) || (state_d == SHIFT);
      reg_mode_d  = 2'b00;
      if (state_d == LOAD)  reg_mode_d = 2'b01;
      if (state_d == SHIFT) reg_mode_d = op_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         reg_mode_q  <= '0;
         reg_enb_q   <= 1'b0;
         reg_d_q     <= '0;
         reg_s_in_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         reg_mode_q  <= reg_mode_d;
         reg_enb_q   <= reg_enb_d;
         reg_d_q     <= reg_d_d;
         reg_s_in_q  <= reg_s_in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign reg_mode  = reg_mode_q;
   assign reg_enb   = reg_enb_q;
   assign reg_d     = reg_d_q;
   assign reg_s_in  = reg_s_in_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef TRANS_CNT_EN
   logic [15:0] tr_cnt_q, tr_cnt_d;

   // Counts each enable burst once, at the edge where REG_ENB rises; saturates.
   always_comb begin
      tr_cnt_d = tr_cnt_q;
      if (reg_enb_d && !reg_enb_q && (tr_cnt_q != 16'hFFFF))
         tr_cnt_d = tr_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tr_cnt_q <= '0;
      else        tr_cnt_q <= tr_cnt_d;
   end

   assign tr_cnt = tr_cnt_q;
`else
   assign tr_cnt = '0;
`endif

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 The block SHALL have parameter SHIFT_W, default 4, giving the width of the controlled shift register.
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of the shift-count field.
REQ-003 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  controller can accept a command.
REQ-007 CMD_OP  input  2  00 nop, 01 parallel load, 10 shift left, 11 shift right.
REQ-008 CMD_N  input  CNT_W  number of shift cycles.
REQ-009 CMD_DATA  input  SHIFT_W  parallel-load data.
REQ-010 S_IN  input  1  serial bit to insert during shifts.
REQ-011 REG_MODE  output  2  mode lines to the shift register.
REQ-012 REG_ENB  output  1  shift-register clock enable.
REQ-013 REG_D  output  SHIFT_W  parallel data to the shift register.
REQ-014 REG_S_IN  output  1  serial input to the shift register.
REQ-015 BUSY  output  1  a command is in progress.
REQ-016 DONE  output  1  one-cycle command-completion pulse.
REQ-017 TR_CNT  output  16  REG_ENB activity count (see Configuration).

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, DONE.
REQ-019 CMD_READY SHALL be 1 only in IDLE; a command is accepted on a rising CLK edge with CMD_VALID=1 and CMD_READY=1.
REQ-020 At accept, CMD_OP, CMD_N, CMD_DATA and S_IN SHALL be latched; later changes on these inputs SHALL have no effect on the running command.
REQ-021 The FSM SHALL move from IDLE to LOAD on an accepted op 01.
REQ-022 The FSM SHALL move from IDLE to SHIFT on an accepted op 10 or 11 with CMD_N>0.
REQ-023 The FSM SHALL move from IDLE directly to DONE on an accepted op 00, or on op 10/11 with CMD_N=0; no REG_ENB pulse is issued in either case.
REQ-024 In LOAD the block SHALL hold REG_MODE=01, REG_ENB=1 and REG_D=latched data for one cycle, then go to DONE.
REQ-025 In SHIFT the block SHALL hold REG_MODE=latched op, REG_ENB=1 and REG_S_IN=latched bit for exactly N cycles, counted by a down-counter, then go to DONE.
REQ-026 DONE SHALL be asserted for one cycle in the DONE state, after which the FSM returns to IDLE.
REQ-027 If acceptance is at edge k: a load SHALL drive REG_ENB in cycle k+1 and DONE in cycle k+2; an N-shift SHALL drive REG_ENB in cycles k+1..k+N and DONE in cycle k+N+1.
REQ-028 Outside LOAD and SHIFT, REG_MODE SHALL be 00 and REG_ENB SHALL be 0; REG_D and REG_S_IN SHALL hold their last values.
REQ-029 BUSY SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-030 The earliest next acceptance SHALL be on the edge ending the IDLE cycle that follows DONE; CMD_VALID while CMD_READY=0 SHALL be ignored and not queued.
REQ-031 All outputs SHALL be driven from registers, with no combinational input-to-output paths.
REQ-032 CMD_N at its maximum value (2^CNT_W-1) SHALL produce exactly that many enable cycles, with no counter wrap.

Reset
REQ-033 RST_N=0 SHALL immediately force the FSM to IDLE and set CMD_READY=1 and every other output to 0, including TR_CNT and the internal counters.
REQ-034 A reset asserted mid-command SHALL abort the command: REG_ENB drops asynchronously and no DONE is issued.
REQ-035 After RST_N deasserts, the first command SHALL be acceptable on the first rising CLK edge.

Configuration
REQ-036 With macro TRANS_CNT_EN defined, TR_CNT SHALL increment by 1 on every 0->1 transition of REG_ENB and saturate at 16'hFFFF; this counter provides the gate-activity power estimate.
REQ-037 Without TRANS_CNT_EN, TR_CNT SHALL be tied to 0, no counter logic is generated, and all other behaviour is unchanged.

Verification
REQ-038 Load: reset, then accept op 01 with DATA=4'b1010 -> one REG_ENB cycle with REG_MODE=01 and REG_D=1010, DONE two cycles after accept.
REQ-039 Shift left: accept op 10, N=3, S_IN=1 -> REG_ENB high for exactly 3 cycles with REG_MODE=10 and REG_S_IN=1, DONE in cycle 4.
REQ-040 Zero/nop: op 11 with N=0, then op 00 -> no REG_ENB, each gives DONE one cycle after accept.
REQ-041 Back-to-back: CMD_VALID held high with op 11, N=7 -> 7 enable cycles, DONE, one IDLE cycle, re-accept; TR_CNT counts 1 per command (macro on) or stays 0 (macro off).
REQ-042 Abort: RST_N pulsed low in the 2nd cycle of an N=5 shift -> REG_ENB=0 immediately, BUSY=0, no DONE, CMD_READY=1.
